// File: rtl/br_ctrl_pkg.sv
// Shared types for the EX-stage branch resolution controller.
// Holds the funct3 encodings, the FSM state enum and the sequential PC step.
package br_ctrl_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_f3_e;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } br_state_e;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/br_taken_dec.sv
// Branch outcome decoder: funct3/jump/less/equal -> taken.
// Latency 0 (pure combinational); no backpressure.
// Flow control: none, evaluated every cycle.
module br_taken_dec
  import br_ctrl_pkg::*;
(
  input  logic       jump,
  input  logic [2:0] funct3,
  input  logic       less,
  input  logic       equal,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    if (jump) begin
      taken = 1'b1;
    end else begin
      case (funct3)
        BEQ:     taken = equal;
        BNE:     taken = ~equal;
        BLT:     taken = less;
        BGE:     taken = ~less;
        BLTU:    taken = less;
        BGEU:    taken = ~less;
        // 010/011 are not branch encodings: never taken
        default: taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/br_resolve_ctrl.sv
// EX-stage branch resolver: decides taken, issues redirect + multi-cycle flush on mispredict.
// Latency 1 cycle from accept to resolved/redirect outputs; ready drops for FLUSH_CYCLES after a mispredict.
// Optional BR_CTRL_STATS_EN adds saturating accept/mispredict counters.
module br_resolve_ctrl
  import br_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
`ifdef BR_CTRL_STATS_EN
  ,
  parameter int CNT_W        = 16
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            br_valid_i,
  output logic            br_ready_o,
  input  logic            br_jump_i,
  input  logic [2:0]      br_funct3_i,
  input  logic            br_pred_taken_i,
  input  logic [XLEN-1:0] br_pc_i,
  input  logic [XLEN-1:0] br_target_i,
  output logic            br_unsigned_o,
  input  logic            br_less_i,
  input  logic            br_equal_i,
  output logic            resolved_valid_o,
  output logic            resolved_taken_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
`ifdef BR_CTRL_STATS_EN
  output logic [CNT_W-1:0] stat_branches_o,
  output logic [CNT_W-1:0] stat_mispred_o,
`endif
  output logic            flush_o
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  br_state_e       state_q, state_d;
  logic [FC_W-1:0] cnt_q, cnt_d;

  logic            taken;
  logic            accept;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc_d;

  // funct3[1] separates BLTU/BGEU from the signed compares
  assign br_unsigned_o = br_funct3_i[1];

  br_taken_dec u_taken_dec (
    .jump   (br_jump_i),
    .funct3 (br_funct3_i),
    .less   (br_less_i),
    .equal  (br_equal_i),
    .taken  (taken)
  );

  // Gated by rst_n so ready reads 0 while reset is asserted
  assign br_ready_o    = rst_n & (state_q == IDLE);
  assign accept        = br_valid_i & br_ready_o;
  assign mispredict    = taken ^ br_pred_taken_i;
  assign redirect_pc_d = taken ? br_target_i : (br_pc_i + XLEN'(PC_STEP));
  assign flush_o       = (state_q == FLUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && mispredict) begin
          state_d = FLUSH;
          cnt_d   = FC_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - FC_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resolved_valid_o <= 1'b0;
      resolved_taken_o <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else begin
      resolved_valid_o <= accept;
      redirect_valid_o <= accept & mispredict;
      if (accept) begin
        resolved_taken_o <= taken;
      end
      if (accept && mispredict) begin
        redirect_pc_o <= redirect_pc_d;
      end
    end
  end

`ifdef BR_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_o <= '0;
      stat_mispred_o  <= '0;
    end else begin
      if (accept && (stat_branches_o != '1)) begin
        stat_branches_o <= stat_branches_o + CNT_W'(1);
      end
      if (accept && mispredict && (stat_mispred_o != '1)) begin
        stat_mispred_o <= stat_mispred_o + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_br_resolve_ctrl.sv
// Directed bench for br_resolve_ctrl; define BR_CTRL_STATS_EN to also exercise the counters.
module tb_br_resolve_ctrl;

  logic        clk;
  logic        rst_n;
  logic        br_valid_i;
  logic        br_ready_o;
  logic        br_jump_i;
  logic [2:0]  br_funct3_i;
  logic        br_pred_taken_i;
  logic [31:0] br_pc_i;
  logic [31:0] br_target_i;
  logic        br_unsigned_o;
  logic        br_less_i;
  logic        br_equal_i;
  logic        resolved_valid_o;
  logic        resolved_taken_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        flush_o;
`ifdef BR_CTRL_STATS_EN
  logic [15:0] stat_branches_o;
  logic [15:0] stat_mispred_o;
  logic        s_ready, s_unsigned, s_rv, s_rt, s_dv, s_flush;
  logic [31:0] s_dpc;
  logic [1:0]  s_branches, s_mispred;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  br_resolve_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .br_valid_i       (br_valid_i),
    .br_ready_o       (br_ready_o),
    .br_jump_i        (br_jump_i),
    .br_funct3_i      (br_funct3_i),
    .br_pred_taken_i  (br_pred_taken_i),
    .br_pc_i          (br_pc_i),
    .br_target_i      (br_target_i),
    .br_unsigned_o    (br_unsigned_o),
    .br_less_i        (br_less_i),
    .br_equal_i       (br_equal_i),
    .resolved_valid_o (resolved_valid_o),
    .resolved_taken_o (resolved_taken_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
`ifdef BR_CTRL_STATS_EN
    .stat_branches_o  (stat_branches_o),
    .stat_mispred_o   (stat_mispred_o),
`endif
    .flush_o          (flush_o)
  );

`ifdef BR_CTRL_STATS_EN
  br_resolve_ctrl #(.CNT_W(2)) dut_small (
    .clk              (clk),
    .rst_n            (rst_n),
    .br_valid_i       (br_valid_i),
    .br_ready_o       (s_ready),
    .br_jump_i        (br_jump_i),
    .br_funct3_i      (br_funct3_i),
    .br_pred_taken_i  (br_pred_taken_i),
    .br_pc_i          (br_pc_i),
    .br_target_i      (br_target_i),
    .br_unsigned_o    (s_unsigned),
    .br_less_i        (br_less_i),
    .br_equal_i       (br_equal_i),
    .resolved_valid_o (s_rv),
    .resolved_taken_o (s_rt),
    .redirect_valid_o (s_dv),
    .redirect_pc_o    (s_dpc),
    .stat_branches_o  (s_branches),
    .stat_mispred_o   (s_mispred),
    .flush_o          (s_flush)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_b(input string tag, input logic obs, input logic exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic j, input logic [2:0] f3, input logic pred,
                       input logic [31:0] pc, input logic [31:0] tgt,
                       input logic lt, input logic eq);
    br_valid_i      = v;
    br_jump_i       = j;
    br_funct3_i     = f3;
    br_pred_taken_i = pred;
    br_pc_i         = pc;
    br_target_i     = tgt;
    br_less_i       = lt;
    br_equal_i      = eq;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #3;
    chk_b("rst_ready", br_ready_o, 1'b0);
    chk_b("rst_flush", flush_o, 1'b0);
    chk_b("rst_resolved", resolved_valid_o, 1'b0);
    chk_b("rst_redirect", redirect_valid_o, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk_b("rel_ready", br_ready_o, 1'b1);
    chk_w("rel_redirect_pc", redirect_pc_o, 32'h0);

    // 1: BEQ equal, predicted not taken -> mispredict to target
    drive(1'b1, 1'b0, 3'b000, 1'b0, 32'h80, 32'h100, 1'b0, 1'b1);
    #1;
    chk_b("t1_unsigned", br_unsigned_o, 1'b0);
    chk_b("t1_ready_pre", br_ready_o, 1'b1);
    step();
    br_valid_i = 1'b0;
    chk_b("t1_resolved", resolved_valid_o, 1'b1);
    chk_b("t1_taken", resolved_taken_o, 1'b1);
    chk_b("t1_redirect", redirect_valid_o, 1'b1);
    chk_w("t1_redirect_pc", redirect_pc_o, 32'h100);
    chk_b("t1_flush_c1", flush_o, 1'b1);
    chk_b("t1_ready_c1", br_ready_o, 1'b0);
    step();
    chk_b("t1_redirect_pulse", redirect_valid_o, 1'b0);
    chk_b("t1_flush_c2", flush_o, 1'b1);
    chk_b("t1_ready_c2", br_ready_o, 1'b0);
    chk_w("t1_pc_held", redirect_pc_o, 32'h100);
    step();
    chk_b("t1_flush_end", flush_o, 1'b0);
    chk_b("t1_ready_end", br_ready_o, 1'b1);

    // 2: BLTU not less, predicted not taken -> correct
    drive(1'b1, 1'b0, 3'b110, 1'b0, 32'h40, 32'h200, 1'b0, 1'b0);
    #1;
    chk_b("t2_unsigned", br_unsigned_o, 1'b1);
    step();
    br_valid_i = 1'b0;
    chk_b("t2_resolved", resolved_valid_o, 1'b1);
    chk_b("t2_taken", resolved_taken_o, 1'b0);
    chk_b("t2_redirect", redirect_valid_o, 1'b0);
    chk_b("t2_flush", flush_o, 1'b0);
    chk_b("t2_ready", br_ready_o, 1'b1);
    chk_w("t2_pc_held", redirect_pc_o, 32'h100);

    // 3: BNE not taken, predicted taken at top of address space -> pc+4 wraps
    drive(1'b1, 1'b0, 3'b001, 1'b1, 32'hFFFF_FFFC, 32'h500, 1'b0, 1'b1);
    step();
    chk_b("t3_redirect", redirect_valid_o, 1'b1);
    chk_w("t3_redirect_pc", redirect_pc_o, 32'h0000_0000);
    chk_b("t3_taken", resolved_taken_o, 1'b0);
    // Next branch held valid during flush must wait for ready
    drive(1'b1, 1'b1, 3'b000, 1'b0, 32'h600, 32'h700, 1'b0, 1'b0);
    step();
    chk_b("t3_hold_resolved", resolved_valid_o, 1'b0);
    chk_b("t3_hold_flush", flush_o, 1'b1);
    step();
    chk_b("t3_hold_ready", br_ready_o, 1'b1);
    chk_b("t3_hold_none", resolved_valid_o, 1'b0);
    step();
    br_valid_i = 1'b0;
    chk_b("t3_jal_resolved", resolved_valid_o, 1'b1);
    chk_b("t3_jal_taken", resolved_taken_o, 1'b1);
    chk_w("t3_jal_pc", redirect_pc_o, 32'h700);
    chk_b("t3_jal_flush", flush_o, 1'b1);
    step();
    step();
    chk_b("t3_ready_back", br_ready_o, 1'b1);

    // 4: back-to-back correctly predicted branches
    drive(1'b1, 1'b0, 3'b101, 1'b1, 32'h10, 32'h20, 1'b0, 1'b0); // BGE taken
    step();
    chk_b("t4a_resolved", resolved_valid_o, 1'b1);
    chk_b("t4a_taken", resolved_taken_o, 1'b1);
    chk_b("t4a_ready", br_ready_o, 1'b1);
    drive(1'b1, 1'b0, 3'b111, 1'b0, 32'h14, 32'h30, 1'b1, 1'b0); // BGEU less -> not taken
    step();
    chk_b("t4b_resolved", resolved_valid_o, 1'b1);
    chk_b("t4b_taken", resolved_taken_o, 1'b0);
    chk_b("t4b_redirect", redirect_valid_o, 1'b0);
    drive(1'b1, 1'b1, 3'b010, 1'b1, 32'h18, 32'h40, 1'b0, 1'b0); // jump overrides 010
    step();
    chk_b("t4c_resolved", resolved_valid_o, 1'b1);
    chk_b("t4c_taken", resolved_taken_o, 1'b1);
    chk_b("t4c_ready", br_ready_o, 1'b1);
    drive(1'b1, 1'b0, 3'b011, 1'b0, 32'h1C, 32'h50, 1'b1, 1'b1); // 011 never taken
    step();
    br_valid_i = 1'b0;
    chk_b("t4d_resolved", resolved_valid_o, 1'b1);
    chk_b("t4d_taken", resolved_taken_o, 1'b0);
    chk_b("t4d_flush", flush_o, 1'b0);
    step();
    chk_b("t4_idle", resolved_valid_o, 1'b0);

    // 5: reset during flush cycle 1
    drive(1'b1, 1'b0, 3'b000, 1'b1, 32'h1000, 32'h2000, 1'b0, 1'b0);
    step();
    br_valid_i = 1'b0;
    chk_b("t5_flush", flush_o, 1'b1);
    chk_w("t5_redirect_pc", redirect_pc_o, 32'h1004);
    #2;
    rst_n = 1'b0;
    #1;
    chk_b("t5_rst_flush", flush_o, 1'b0);
    chk_b("t5_rst_redirect", redirect_valid_o, 1'b0);
    chk_b("t5_rst_resolved", resolved_valid_o, 1'b0);
    chk_b("t5_rst_taken", resolved_taken_o, 1'b0);
    chk_w("t5_rst_pc", redirect_pc_o, 32'h0);
    chk_b("t5_rst_ready", br_ready_o, 1'b0);
    step();
    rst_n = 1'b1;
    #1;
    chk_b("t5_rel_ready", br_ready_o, 1'b1);
    step();
    chk_b("t5_no_replay", redirect_valid_o, 1'b0);
    chk_b("t5_no_flush", flush_o, 1'b0);

`ifdef BR_CTRL_STATS_EN
    // 6: five accepts, two of them mispredicted
    drive(1'b1, 1'b0, 3'b000, 1'b1, 32'h0, 32'h80, 1'b0, 1'b1);
    step();
    drive(1'b1, 1'b0, 3'b100, 1'b0, 32'h4, 32'h80, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b1, 3'b000, 1'b0, 32'h8, 32'h80, 1'b0, 1'b0);
    step();
    br_valid_i = 1'b0;
    step();
    step();
    drive(1'b1, 1'b0, 3'b001, 1'b1, 32'hC, 32'h80, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b0, 3'b000, 1'b1, 32'h10, 32'h80, 1'b0, 1'b0);
    step();
    br_valid_i = 1'b0;
    step();
    step();
    chk_w("t6_branches", 32'(stat_branches_o), 32'd5);
    chk_w("t6_mispred", 32'(stat_mispred_o), 32'd2);
    chk_w("t6_sat_branches", 32'(s_branches), 32'd3);
    chk_w("t6_small_mispred", 32'(s_mispred), 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
